// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU through an
// IDLE/RESP handshake FSM, with at most one transaction outstanding.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins
// ties and the last-grant register is dropped. Default is round-robin.
//
// state | meaning
// IDLE  | no transaction held; combinational grant, req_ready to winner
// RESP  | transaction held; rsp_valid to owner until owner rsp_ready

module alu #(
   parameter int XLEN = 32
) (
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic [XLEN-1:0] o_res,
   output logic            o_err
);
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_XOR = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_AND = 3'd4;

   // Result wraps modulo 2^XLEN; unsupported codes give 0 and flag an error.
   always_comb begin
      o_res = '0;
      o_err = 1'b0;
      case (i_op)
         ALU_ADD: o_res = i_a + i_b;
         ALU_SUB: o_res = i_a - i_b;
         ALU_XOR: o_res = i_a ^ i_b;
         ALU_OR:  o_res = i_a | i_b;
         ALU_AND: o_res = i_a & i_b;
         default: o_err = 1'b1;
      endcase
   end
endmodule

module alu_arbiter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid_0,
   input  logic            req_valid_1,
   output logic            req_ready_0,
   output logic            req_ready_1,
   input  logic [2:0]      req_op_0,
   input  logic [2:0]      req_op_1,
   input  logic [XLEN-1:0] req_a_0,
   input  logic [XLEN-1:0] req_a_1,
   input  logic [XLEN-1:0] req_b_0,
   input  logic [XLEN-1:0] req_b_1,
   output logic            rsp_valid_0,
   output logic            rsp_valid_1,
   input  logic            rsp_ready_0,
   input  logic            rsp_ready_1,
   output logic [XLEN-1:0] rsp_data_0,
   output logic [XLEN-1:0] rsp_data_1,
   output logic            rsp_err_0,
   output logic            rsp_err_1,
   output logic            busy
);
   typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_t;

   state_t            r_state;
   logic              r_owner;
   logic [2:0]        r_op;
   logic [XLEN-1:0]   r_a;
   logic [XLEN-1:0]   r_b;
   logic              w_gnt_0;
   logic              w_gnt_1;
   logic              w_idle;
   logic              w_acc_0;
   logic              w_acc_1;
   logic              w_take;
   logic [XLEN-1:0]   w_res;
   logic              w_err;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign w_gnt_0 = req_valid_0;
   assign w_gnt_1 = req_valid_1 & ~req_valid_0;
`else
   logic              r_last;
   assign w_gnt_0 = req_valid_0 & (~req_valid_1 | r_last);
   assign w_gnt_1 = req_valid_1 & (~req_valid_0 | ~r_last);
`endif

   // rst_n gating keeps req_ready low while reset is asserted even if a
   // requester already presents valid.
   assign w_idle      = rst_n & (r_state == ST_IDLE);
   assign req_ready_0 = w_idle & w_gnt_0;
   assign req_ready_1 = w_idle & w_gnt_1;
   assign w_acc_0     = req_valid_0 & req_ready_0;
   assign w_acc_1     = req_valid_1 & req_ready_1;
   assign w_take      = r_owner ? rsp_ready_1 : rsp_ready_0;

   alu #(.XLEN(XLEN)) u_alu (
      .i_op  (r_op),
      .i_a   (r_a),
      .i_b   (r_b),
      .o_res (w_res),
      .o_err (w_err)
   );

   // Response side is pure decode of registered state and operands, so it
   // stays stable for as long as the owner stalls.
   assign busy        = (r_state == ST_RESP);
   assign rsp_valid_0 = busy & ~r_owner;
   assign rsp_valid_1 = busy &  r_owner;
   assign rsp_data_0  = rsp_valid_0 ? w_res : '0;
   assign rsp_data_1  = rsp_valid_1 ? w_res : '0;
   assign rsp_err_0   = rsp_valid_0 & w_err;
   assign rsp_err_1   = rsp_valid_1 & w_err;

   // Handshake FSM: capture the granted request, then hold until the owner consumes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_owner <= 1'b0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         r_last  <= 1'b1;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_acc_0 | w_acc_1) begin
                  r_state <= ST_RESP;
                  r_owner <= w_acc_1;
                  r_op    <= w_acc_1 ? req_op_1 : req_op_0;
                  r_a     <= w_acc_1 ? req_a_1  : req_a_0;
                  r_b     <= w_acc_1 ? req_b_1  : req_b_0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                  r_last  <= w_acc_1;
`endif
               end
            end
            ST_RESP: begin
               if (w_take) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_XOR = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_BAD = 3'd6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid_0, req_valid_1, req_ready_0, req_ready_1;
   logic [2:0]  req_op_0, req_op_1;
   logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
   logic        rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
   logic [31:0] rsp_data_0, rsp_data_1;
   logic        rsp_err_0, rsp_err_1, busy;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   checks   = 0;
   int   failures = 0;
   logic model_last;
   logic exp_g;

   alu_arbiter #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
      .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
      .req_op_0(req_op_0), .req_op_1(req_op_1),
      .req_a_0(req_a_0), .req_a_1(req_a_1),
      .req_b_0(req_b_0), .req_b_1(req_b_1),
      .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
      .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
      .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1),
      .rsp_err_0(rsp_err_0), .rsp_err_1(rsp_err_1),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: a response transfers when valid and ready are both high.
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid_0 && rsp_ready_0) begin
         if (q0.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp0_unexpected data=0x%08h err=%0b expected=none", rsp_data_0, rsp_err_0);
         end else begin
            e = q0.pop_front();
            chk("rsp0_data", rsp_data_0, e.data);
            chk("rsp0_err", {31'd0, rsp_err_0}, {31'd0, e.err});
         end
      end
      if (rsp_valid_1 && rsp_ready_1) begin
         if (q1.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp1_unexpected data=0x%08h err=%0b expected=none", rsp_data_1, rsp_err_1);
         end else begin
            e = q1.pop_front();
            chk("rsp1_data", rsp_data_1, e.data);
            chk("rsp1_err", {31'd0, rsp_err_1}, {31'd0, e.err});
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      req_valid_0 = 1'b1; req_op_0 = OP_ADD; req_a_0 = 32'd5;  req_b_0 = 32'd3;
      req_valid_1 = 1'b1; req_op_1 = OP_ADD; req_a_1 = 32'd10; req_b_1 = 32'd20;
      rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready_0", {31'd0, req_ready_0}, 32'd0);
      chk("rst_req_ready_1", {31'd0, req_ready_1}, 32'd0);
      chk("rst_rsp_valid_0", {31'd0, rsp_valid_0}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rsp_data_0", rsp_data_0, 32'd0);

      // First tie after reset goes to requester 0; ADD 5+3.
      rst_n = 1'b1;
      #1;
      chk("first_gnt_ready_0", {31'd0, req_ready_0}, 32'd1);
      chk("first_gnt_ready_1", {31'd0, req_ready_1}, 32'd0);
      q0.push_back('{data: 32'd8, err: 1'b0});
      step();
      req_valid_0 = 1'b0;
      chk("lat1_rsp_valid_0", {31'd0, rsp_valid_0}, 32'd1);
      chk("lat1_rsp_valid_1", {31'd0, rsp_valid_1}, 32'd0);
      chk("lat1_busy", {31'd0, busy}, 32'd1);
      chk("resp_ready_1_low", {31'd0, req_ready_1}, 32'd0);
      step();
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("solo_ready_1", {31'd0, req_ready_1}, 32'd1);
      q1.push_back('{data: 32'd30, err: 1'b0});
      step();
      req_valid_1 = 1'b0;
      step();

      // Back-to-back contention: OR 0x00FF0000|0x0000FF00, AND 0xFFFF0000&0x0FF00FF0.
      req_op_0 = OP_OR;  req_a_0 = 32'h00FF0000; req_b_0 = 32'h0000FF00;
      req_op_1 = OP_AND; req_a_1 = 32'hFFFF0000; req_b_1 = 32'h0FF00FF0;
      req_valid_0 = 1'b1; req_valid_1 = 1'b1;
      model_last = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         exp_g = 1'b0;
`else
         exp_g = ~model_last;
`endif
         chk($sformatf("rr_gnt%0d_ready_0", i), {31'd0, req_ready_0}, {31'd0, ~exp_g});
         chk($sformatf("rr_gnt%0d_ready_1", i), {31'd0, req_ready_1}, {31'd0, exp_g});
         if (exp_g) q1.push_back('{data: 32'h0FF00000, err: 1'b0});
         else       q0.push_back('{data: 32'h00FFFF00, err: 1'b0});
         model_last = exp_g;
         step();
         step();
      end
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      step();

      // Owner 1 stalls: SUB 0-1 wraps to all ones and must hold.
      rsp_ready_1 = 1'b0;
      req_op_1 = OP_SUB; req_a_1 = 32'd0; req_b_1 = 32'd1; req_valid_1 = 1'b1;
      #1;
      chk("sub_ready_1", {31'd0, req_ready_1}, 32'd1);
      q1.push_back('{data: 32'hFFFFFFFF, err: 1'b0});
      step();
      req_valid_1 = 1'b0;
      req_op_0 = OP_BAD; req_a_0 = 32'h0000FFFF; req_b_0 = 32'd1; req_valid_0 = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("stall%0d_valid_1", i), {31'd0, rsp_valid_1}, 32'd1);
         chk($sformatf("stall%0d_data_1", i), rsp_data_1, 32'hFFFFFFFF);
         chk($sformatf("stall%0d_ready_0", i), {31'd0, req_ready_0}, 32'd0);
         chk($sformatf("stall%0d_ready_1", i), {31'd0, req_ready_1}, 32'd0);
         chk($sformatf("stall%0d_busy", i), {31'd0, busy}, 32'd1);
         step();
      end
      rsp_ready_1 = 1'b1;
      step();
      rsp_ready_1 = 1'b0;

      // Illegal op from requester 0.
      #1;
      chk("bad_ready_0", {31'd0, req_ready_0}, 32'd1);
      q0.push_back('{data: 32'd0, err: 1'b1});
      rsp_ready_0 = 1'b1;
      step();
      req_valid_0 = 1'b0;
      chk("bad_err_0", {31'd0, rsp_err_0}, 32'd1);
      chk("bad_data_0", rsp_data_0, 32'd0);
      step();

      // XOR with non-owner rsp_ready pulsed; response must stay held.
      rsp_ready_0 = 1'b0;
      req_op_0 = OP_XOR; req_a_0 = 32'hF0F0F0F0; req_b_0 = 32'hFFFF0000; req_valid_0 = 1'b1;
      #1;
      chk("xor_ready_0", {31'd0, req_ready_0}, 32'd1);
      q0.push_back('{data: 32'h0F0FF0F0, err: 1'b0});
      step();
      req_valid_0 = 1'b0;
      rsp_ready_1 = 1'b1;
      step();
      rsp_ready_1 = 1'b0;
      chk("nonowner_ignored_valid_0", {31'd0, rsp_valid_0}, 32'd1);
      chk("nonowner_ignored_data_0", rsp_data_0, 32'h0F0FF0F0);
      step();
      chk("xor_hold_valid_0", {31'd0, rsp_valid_0}, 32'd1);
      rsp_ready_0 = 1'b1;
      step();
      rsp_ready_0 = 1'b0;

      // Reset while holding a response: discarded, never delivered.
      req_op_0 = OP_ADD; req_a_0 = 32'd1; req_b_0 = 32'd1; req_valid_0 = 1'b1;
      #1;
      chk("disc_ready_0", {31'd0, req_ready_0}, 32'd1);
      step();
      req_valid_0 = 1'b0;
      chk("disc_rsp_valid_0", {31'd0, rsp_valid_0}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("disc_rst_valid_0", {31'd0, rsp_valid_0}, 32'd0);
      chk("disc_rst_busy", {31'd0, busy}, 32'd0);
      chk("disc_rst_data_0", rsp_data_0, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("post_rst%0d_valid_0", i), {31'd0, rsp_valid_0}, 32'd0);
         chk($sformatf("post_rst%0d_busy", i), {31'd0, busy}, 32'd0);
         step();
      end

      chk("q0_drained", q0.size(), 32'd0);
      chk("q1_drained", q1.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 The block SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have ports, for i in {0,1}: req_valid_i  input  1  request present.
REQ-005 The block SHALL have ports: req_ready_i  output  1  request accepted this cycle when high with req_valid_i.
REQ-006 The block SHALL have ports: req_op_i  input  3  operation, ALU_OP code.
REQ-007 The block SHALL have ports: req_a_i, req_b_i  input  XLEN  operands in1, in2.
REQ-008 The block SHALL have ports: rsp_valid_i  output  1  result for requester i available.
REQ-009 The block SHALL have ports: rsp_ready_i  input  1  requester i consumes result.
REQ-010 The block SHALL have ports: rsp_data_i  output  XLEN  result; rsp_err_i  output  1  illegal op.
REQ-011 The block SHALL have port: busy  output  1  a transaction is held in the block.

Function
REQ-012 The block SHALL instantiate exactly one alu and share it between requesters 0 and 1.
REQ-013 The block SHALL implement states IDLE and RESP; one transaction outstanding at most.
REQ-014 In IDLE, grant SHALL be combinational: only one valid -> that requester; both valid -> requester not granted last.
REQ-015 req_ready_i SHALL be high only in IDLE and only for the granted requester; low in RESP for both.
REQ-016 On req_valid_i & req_ready_i the block SHALL register op, a, b, owner id, update last-grant to i, go to RESP.
REQ-017 In RESP, rsp_valid SHALL be high for the owner only; rsp_data driven from alu on registered operands; latency 1 cycle from acceptance.
REQ-018 rsp_data, rsp_err SHALL remain stable while rsp_valid high and rsp_ready low.
REQ-019 On owner rsp_ready high in RESP, the block SHALL return to IDLE next cycle; new acceptance earliest that IDLE cycle (max 1 transaction / 2 cycles).
REQ-020 rsp_ready of the non-owner SHALL be ignored.
REQ-021 rsp_err SHALL be high with rsp_valid when op is not ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND; rsp_data then 0.
REQ-022 Arithmetic SHALL wrap modulo 2^XLEN; no carry or overflow output.
REQ-023 Requesters SHALL hold req_valid, op, operands stable until accepted; req_valid dropping before acceptance withdraws the request without effect.
REQ-024 busy SHALL equal (state == RESP).

Reset
REQ-025 rst_n low SHALL immediately force IDLE, last-grant = 1 (requester 0 wins first tie), owner 0, operand/op registers 0.
REQ-026 During reset all req_ready, rsp_valid, rsp_err, busy SHALL be 0 and rsp_data 0.
REQ-027 Reset in RESP SHALL discard the held transaction; no response is ever produced for it.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 SHALL always win when both valid; last-grant register omitted.
REQ-029 Macro ALU_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-014.

Verification
REQ-030 Reset release, both valid, op ADD, a=5, b=3 -> requester 0 granted, cycle+1 rsp_valid_0, rsp_data_0=8, rsp_err_0=0.
REQ-031 Both valid continuously, rsp_ready both high -> grants alternate 0,1,0,1 (round-robin); always 0 with ALU_ARB_FIXED_PRIO_EN.
REQ-032 Req1 SUB a=0, b=1, rsp_ready_1 held low 4 cycles -> rsp_data_1=0xFFFFFFFF stable 4 cycles, req_ready both 0, busy 1.
REQ-033 Req0 with op not in legal set, a=0xFFFF, b=1 -> rsp_err_0=1, rsp_data_0=0.
REQ-034 rst_n low in RESP with rsp_valid_0 high -> rsp_valid_0, busy 0 immediately; after release no stale response.
REQ-035 Req0 XOR a=0xF0F0F0F0, b=0xFFFF0000, rsp_ready_1 pulsed only -> response held until rsp_ready_0; result 0x0F0FF0F0.
